// File: rtl/vga_pkg.sv
// Timing constants for 1024x768@60 Hz with a 65 MHz pixel clock.
// Every module of the raster pipeline takes its default geometry from here.
package vga_pkg;

    localparam int CNT_W          = 11;
    localparam int FRAME_CNT_W    = 16;

    localparam int HOR_PIXELS     = 1024;
    localparam int H_FRONT_PORCH  = 24;
    localparam int H_SYNC_WIDTH   = 136;
    localparam int H_BACK_PORCH   = 160;
    localparam int H_TOTAL_TIME   = HOR_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;

    localparam int VER_PIXELS     = 768;
    localparam int V_FRONT_PORCH  = 3;
    localparam int V_SYNC_WIDTH   = 6;
    localparam int V_BACK_PORCH   = 29;
    localparam int V_TOTAL_TIME   = VER_PIXELS + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

endpackage

// File: rtl/vga_if_no_rgb.sv
// Raster timing bus without colour: counts plus sync and blanking flags.
// The generator drives it through tim_out, drawing stages read it through tim_in.
interface vga_if_no_rgb;

    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;

    modport tim_out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
    modport tim_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);

endinterface

// File: rtl/vga_timing_gen_sync_counter.sv
// One raster axis: a wrapping counter with enable and carry-in, plus blank and
// sync flags decoded from the next count so they register alongside the count.
module sync_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL_TIME,
    parameter int ACTIVE     = HOR_PIXELS,
    parameter int SYNC_START = HOR_PIXELS + H_FRONT_PORCH,
    parameter int SYNC_END   = HOR_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             carry_in,
    output logic [CNT_W-1:0] count,
    output logic             terminal,
    output logic             blank,
    output logic             sync,
    output logic             start_pulse
);

    // Twelve-bit bounds so a range ending exactly at 2048 still compares correctly.
    localparam logic [CNT_W-1:0] LAST         = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W:0]   ACTIVE_W     = (CNT_W + 1)'(ACTIVE);
    localparam logic [CNT_W:0]   SYNC_START_W = (CNT_W + 1)'(SYNC_START);
    localparam logic [CNT_W:0]   SYNC_END_W   = (CNT_W + 1)'(SYNC_END);

    logic             step;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W:0]   next_wide;

    // Work out the next count; terminal flags the wrap and feeds the next axis.
    always_comb begin
        step       = en && carry_in;
        terminal   = step && (count == LAST);
        count_next = count;
        if (terminal) begin
            count_next = '0;
        end else if (step) begin
            count_next = count + CNT_W'(1);
        end
    end

    assign next_wide = {1'b0, count_next};

    // Register count, flags and the wrap pulse together so they never skew.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            blank       <= 1'b0;
            sync        <= 1'b0;
            start_pulse <= 1'b0;
        end else begin
            count       <= count_next;
            blank       <= (next_wide >= ACTIVE_W);
            sync        <= (next_wide >= SYNC_START_W) && (next_wide < SYNC_END_W);
            start_pulse <= terminal;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Producer of the VGA raster timing bus plus frame bookkeeping for game logic.
// The vertical axis is carried by the horizontal wrap; a vertical wrap is a new frame.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = HOR_PIXELS,
    parameter int H_FP     = H_FRONT_PORCH,
    parameter int H_SYNC   = H_SYNC_WIDTH,
    parameter int H_BP     = H_BACK_PORCH,
    parameter int V_ACTIVE = VER_PIXELS,
    parameter int V_FP     = V_FRONT_PORCH,
    parameter int V_SYNC   = V_SYNC_WIDTH,
    parameter int V_BP     = V_BACK_PORCH
) (
    input  logic                   clk65MHz,
    input  logic                   rst,
    input  logic                   en,
    vga_if_no_rgb.tim_out          timing_if,
    output logic                   frame_start,
    output logic                   line_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             h_terminal;
    logic             v_terminal;
    logic             h_blank;
    logic             h_sync;
    logic             v_blank;
    logic             v_sync;

    sync_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
    ) u_h_counter (
        .clk         (clk65MHz),
        .rst         (rst),
        .en          (en),
        .carry_in    (1'b1),
        .count       (h_count),
        .terminal    (h_terminal),
        .blank       (h_blank),
        .sync        (h_sync),
        .start_pulse (line_start)
    );

    sync_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_v_counter (
        .clk         (clk65MHz),
        .rst         (rst),
        .en          (en),
        .carry_in    (h_terminal),
        .count       (v_count),
        .terminal    (v_terminal),
        .blank       (v_blank),
        .sync        (v_sync),
        .start_pulse (frame_start)
    );

    assign timing_if.hcount = h_count;
    assign timing_if.vcount = v_count;
    assign timing_if.hsync  = h_sync;
    assign timing_if.vsync  = v_sync;
    assign timing_if.hblnk  = h_blank;
    assign timing_if.vblnk  = v_blank;

    // Count completed frames; bumps in the same cycle frame_start is registered.
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (v_terminal) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end

endmodule
